syn_perf_counters: RTL
======================

Name: syn_perf_counters

Overview:
- Parametrised event and cycle counter bank for the CPU top.
- Counts core cycles plus NUM_CH per-cycle event strobes, e.g. is_jump, is_branch, branched, syscall.
- Freezes on halt, gated by the same en as the core.
- Exposes a live debug readback mux and an atomic four-phase snapshot for board display or bench checking.

Parameters:
- NUM_CH, 4: number of event channels (1..15).
- CNT_W, 32: counter width in bits (8..64).
- SAT, 0: overflow mode. 0 = wrap, 1 = saturate at all-ones.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- en  in  1  global enable, same signal that gates PC/RegFile/DataMem.
- halt  in  1  core halt flag.
- ev  in  NUM_CH  event strobes, one bit per channel, sampled each enabled cycle.
- clr  in  1  synchronous clear of counters, overflow flags and FSM.
- snap_req  in  1  snapshot request, level, four-phase.
- snap_ack  out  1  snapshot acknowledge.
- sel_dbg  in  4  readback select. 0..NUM_CH-1 = channels, NUM_CH = cycle counter.
- cnt_dbg  out  CNT_W  live value of the selected counter.
- snap_dbg  out  CNT_W  snapshot value of the selected counter.
- ovf  out  NUM_CH+1  sticky overflow flags. Bit NUM_CH = cycle counter.
- running  out  1  high while FSM is in RUN.
- thresh  in  CNT_W  cycle threshold, used only with the optional feature.
- irq  out  1  threshold interrupt, used only with the optional feature.

Behaviour:
- Reset (rst_n=0 at a clk edge): all counters, shadows, ovf, snap_ack and irq = 0. FSM = IDLE, running = 0.
- FSM states:
  - IDLE -> RUN on the first cycle with en=1. That cycle is already counted.
  - RUN -> HALTED when en=1 and halt=1. The halt cycle is counted; later cycles are not.
  - HALTED -> IDLE only on clr.
  - en=0 in any state: no state change, no counting.
- Counting (RUN, or the IDLE->RUN cycle, with en=1):
  - Cycle counter += 1.
  - Channel i += ev[i].
  - Updates are registered: cnt_dbg shows the new value one cycle after the event.
- Width and overflow:
  - SAT=0: all-ones + 1 -> 0, and the ovf bit is set.
  - SAT=1: the counter holds all-ones, and the ovf bit is set on the first attempted increment past all-ones.
  - ovf bits are sticky until clr or reset.
- clr:
  - Zeroes counters and ovf, clears irq, FSM -> IDLE. It does not touch the shadows or snap_ack.
  - clr wins over a same-cycle increment. Reset wins over clr.
- Snapshot, four-phase handshake:
  - When snap_req=1 and snap_ack=0, all NUM_CH+1 counters are copied to the shadows in the same cycle. The copied values are the pre-increment and pre-clr values of that cycle.
  - snap_ack rises the next cycle and stays high while snap_req=1.
  - snap_ack falls the cycle after snap_req falls.
  - A new capture requires snap_ack=0.
  - Snapshot ignores en and runs in every FSM state.
- Readback:
  - cnt_dbg and snap_dbg are combinational muxes on sel_dbg.
  - sel_dbg > NUM_CH -> 0 on both.

Optional Feature:
- Macro PERF_CNT_IRQ_EN.
- Defined: irq is set one cycle after the cycle counter's registered value equals thresh while in RUN. irq is sticky until clr or reset. thresh=0 never fires.
- Undefined: irq is tied 0, thresh is ignored, no comparator is built. The ports are present in both builds.

Decomposition:
- Shared package/header (alongside Core.vh), holding:
  - PERF_ST_BIT and the state encodings PERF_ST_IDLE, PERF_ST_RUN, PERF_ST_HALT.
  - PERF_SEL_BIT = 4.
- One natural sub-module, syn_perf_counter: a single CNT_W counter with inc, clr, SAT mode and a sticky ovf output. It is instantiated NUM_CH+1 times.
- The FSM, snapshot handshake and readback mux stay in the top.

Test Plan:
- Reset, then en=1 for 10 cycles with ev=4'b0001 every cycle -> cycle counter = 10, channel 0 = 10, other channels 0, running=1.
- RUN, halt=1 on cycle 5 of en=1 -> cycle counter freezes at 5, running=0. 20 further cycles with ev=4'hF -> all counters unchanged. clr -> all 0, IDLE.
- CNT_W=8, SAT=0: 257 enabled cycles -> cycle counter = 1, ovf[NUM_CH]=1. Same with SAT=1 -> counter = 255, ovf=1.
- snap_req raised at a cycle count of 7, counting continues -> snap_ack high the next cycle, snap_dbg(sel=NUM_CH)=7 while cnt_dbg keeps rising. Drop snap_req -> snap_ack low one cycle later.
- Same-cycle clr + snap_req + ev=4'h1 with channel 0 at 42 -> shadow 0 = 42, live channel 0 = 0 afterwards. sel_dbg=9 -> cnt_dbg=0 and snap_dbg=0.
- PERF_CNT_IRQ_EN defined, thresh=3 -> irq rises one cycle after the cycle counter reads 3 and stays high until clr. Undefined build -> irq stays 0 throughout.

Source files
------------

// File: rtl/syn_perf_counters_pkg.sv
// Shared definitions for the performance counter bank: FSM state encodings
// and the width of the debug readback select.
package syn_perf_counters_pkg;

    localparam int PERF_ST_BIT  = 2;
    localparam int PERF_SEL_BIT = 4;

    typedef enum logic [PERF_ST_BIT-1:0] {
        PERF_ST_IDLE = 2'd0,
        PERF_ST_RUN  = 2'd1,
        PERF_ST_HALT = 2'd2
    } perf_st_e;

endpackage

// File: rtl/syn_perf_counter.sv
// Single CNT_W event counter with synchronous clear, wrap or saturate
// overflow behaviour (SAT) and a sticky overflow flag.
module syn_perf_counter
    import syn_perf_counters_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int SAT   = 0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    // Next count: clear dominates, then increment with wrap or saturation.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc_i) begin
            if (&cnt_q) begin
                ovf_d = 1'b1;
                cnt_d = (SAT != 0) ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter and overflow flag registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/syn_perf_counters.sv
// Cycle and event counter bank for the CPU top. Counts while the core runs,
// freezes on halt, offers a live readback mux and a four-phase snapshot.
// Optional threshold interrupt is built when PERF_CNT_IRQ_EN is defined;
// otherwise irq is tied low and thresh is ignored.
module syn_perf_counters
    import syn_perf_counters_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int SAT    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    halt,
    input  logic [NUM_CH-1:0]       ev,
    input  logic                    clr,
    input  logic                    snap_req,
    output logic                    snap_ack,
    input  logic [PERF_SEL_BIT-1:0] sel_dbg,
    output logic [CNT_W-1:0]        cnt_dbg,
    output logic [CNT_W-1:0]        snap_dbg,
    output logic [NUM_CH:0]         ovf,
    output logic                    running,
    input  logic [CNT_W-1:0]        thresh,
    output logic                    irq
);

    perf_st_e         state_q, state_d;
    logic             count_en;
    logic [NUM_CH:0]  inc_all;
    logic [CNT_W-1:0] cnt_all    [0:NUM_CH];
    logic [CNT_W-1:0] shadow_q   [0:NUM_CH];
    logic             snap_ack_q, snap_ack_d;
    logic             capture;

    // FSM next state; counting happens on the IDLE->RUN cycle, in RUN, and on the halt cycle.
    always_comb begin
        state_d  = state_q;
        count_en = 1'b0;
        case (state_q)
            PERF_ST_IDLE: begin
                if (en) begin
                    state_d  = PERF_ST_RUN;
                    count_en = 1'b1;
                end
            end
            PERF_ST_RUN: begin
                if (en) begin
                    count_en = 1'b1;
                    if (halt) state_d = PERF_ST_HALT;
                end
            end
            PERF_ST_HALT: state_d = PERF_ST_HALT;
            default:      state_d = PERF_ST_IDLE;
        endcase
        if (clr) state_d = PERF_ST_IDLE;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= PERF_ST_IDLE;
        else        state_q <= state_d;
    end

    assign running = (state_q == PERF_ST_RUN);
    assign inc_all = {count_en, ev & {NUM_CH{count_en}}};

    // Channels 0..NUM_CH-1 are event counters; index NUM_CH is the cycle counter.
    for (genvar g = 0; g <= NUM_CH; g++) begin : g_cnt
        syn_perf_counter #(
            .CNT_W (CNT_W),
            .SAT   (SAT)
        ) u_cnt (
            .clk_i   (clk),
            .rst_n_i (rst_n),
            .inc_i   (inc_all[g]),
            .clr_i   (clr),
            .cnt_o   (cnt_all[g]),
            .ovf_o   (ovf[g])
        );
    end

    // A capture is taken only when the previous handshake has fully closed.
    assign capture    = snap_req && !snap_ack_q;
    assign snap_ack_d = snap_req;

    // Snapshot shadows and acknowledge; shadows hold the pre-update register values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_ack_q <= 1'b0;
            for (int i = 0; i <= NUM_CH; i++) shadow_q[i] <= '0;
        end else begin
            snap_ack_q <= snap_ack_d;
            if (capture) begin
                for (int i = 0; i <= NUM_CH; i++) shadow_q[i] <= cnt_all[i];
            end
        end
    end

    assign snap_ack = snap_ack_q;

    // Readback muxes; out-of-range selects read as zero.
    always_comb begin
        cnt_dbg  = '0;
        snap_dbg = '0;
        for (int i = 0; i <= NUM_CH; i++) begin
            if (sel_dbg == PERF_SEL_BIT'(i)) begin
                cnt_dbg  = cnt_all[i];
                snap_dbg = shadow_q[i];
            end
        end
    end

`ifdef PERF_CNT_IRQ_EN
    logic irq_q, irq_d;

    // Sticky threshold interrupt on the registered cycle count; zero threshold disables it.
    always_comb begin
        irq_d = irq_q;
        if (clr) begin
            irq_d = 1'b0;
        end else if ((state_q == PERF_ST_RUN) && (thresh != '0) &&
                     (cnt_all[NUM_CH] == thresh)) begin
            irq_d = 1'b1;
        end
    end

    // Interrupt flag register.
    always_ff @(posedge clk) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= irq_d;
    end

    assign irq = irq_q;
`else
    logic unused_thresh;
    assign unused_thresh = ^thresh;
    assign irq = 1'b0;
`endif

endmodule
